// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 register numbers, exception codes and the
// exception vector used by the CP0 unit and its timer.
package cpu_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI latches on a
// Count==Compare match and is cleared only by a Compare write.
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_toggle;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_armed;
    logic        r_ti;
    logic        w_hit;

    // A reset-time Compare of 0 must not fire at Count 0 until software arms it.
    assign w_hit = (r_count == r_compare) && (r_armed || (r_compare != 32'd0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_toggle  <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_armed   <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            r_toggle <= ~r_toggle;
            if (i_count_we)
                r_count <= i_wdata;
            else if (r_toggle)
                r_count <= r_count + 32'd1;
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_armed   <= 1'b1;
                r_ti      <= 1'b0;
            end else if (w_hit) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_unit.sv
// CP0 system coprocessor: exception entry/return, Status/Cause/EPC/BadVAddr
// state, timer interrupt and the pipeline flush/redirect.
module cp0_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_valid,
    input  logic [30:0] exc_cause,
    input  logic [31:0] exc_badvaddr,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] mtc0_wdata,
    output logic [31:0] mfc0_rdata,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        int_req
);

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_int_req;

    logic        w_mtc0;
    logic [4:0]  w_code;
    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [7:0]  w_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_unused_cause;

    assign w_code         = exc_cause[6:2];
    assign w_unused_cause = &{1'b0, exc_cause[30:7], exc_cause[1:0]};

    // Exception beats ERET beats mtc0; a losing write is dropped entirely.
    assign w_mtc0 = mtc0_we & ~exc_valid & ~eret;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_we   (w_mtc0 && (cp0_addr == CP0_COUNT)),
        .i_compare_we (w_mtc0 && (cp0_addr == CP0_COMPARE)),
        .i_wdata      (mtc0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // IP[14:10] have no external sources in this core.
    assign w_ip     = {w_ti, 5'b0, r_ip_sw};
    assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exc_code, 2'b0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im       <= STATUS_RESET[15:8];
            r_exl      <= STATUS_RESET[1];
            r_ie       <= STATUS_RESET[0];
            r_bd       <= 1'b0;
            r_ip_sw    <= 2'b0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_int_req  <= 1'b0;
        end else begin
            r_int_req <= r_ie & ~r_exl & (|(w_ip & r_im));
            if (exc_valid) begin
                // Nested exceptions keep the original return point.
                if (!r_exl) begin
                    r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
                    r_bd  <= exc_bd;
                end
                r_exl      <= 1'b1;
                r_exc_code <= w_code;
                if (w_code == EXC_ADEL || w_code == EXC_ADES)
                    r_badvaddr <= exc_badvaddr;
            end else if (eret) begin
                r_exl <= 1'b0;
            end else if (w_mtc0) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        r_im  <= mtc0_wdata[15:8];
                        r_exl <= mtc0_wdata[1];
                        r_ie  <= mtc0_wdata[0];
                    end
                    CP0_CAUSE:    r_ip_sw    <= mtc0_wdata[9:8];
                    CP0_EPC:      r_epc      <= mtc0_wdata;
                    CP0_BADVADDR: r_badvaddr <= mtc0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        mfc0_rdata = 32'd0;
        case (cp0_addr)
            CP0_BADVADDR: mfc0_rdata = r_badvaddr;
            CP0_COUNT:    mfc0_rdata = w_count;
            CP0_COMPARE:  mfc0_rdata = w_compare;
            CP0_STATUS:   mfc0_rdata = w_status;
            CP0_CAUSE:    mfc0_rdata = w_cause;
            CP0_EPC:      mfc0_rdata = r_epc;
            default:      mfc0_rdata = 32'd0;
        endcase
    end

    assign flush    = resetn & (exc_valid | eret);
    assign flush_pc = exc_valid ? EXC_VECTOR : r_epc;
    assign int_req  = r_int_req;

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port exc_valid, input, 1, exception reported by the pipeline's memory-commit point.
REQ-004 SHALL have port exc_cause, input, 31, the Cause[30:0] image carried with the exception, ExcCode in [6:2].
REQ-005 SHALL have port exc_badvaddr, input, 32, faulting address, meaningful for ExcCode 4/5 only.
REQ-006 SHALL have port exc_pc, input, 32, PC of the excepting instruction.
REQ-007 SHALL have port exc_bd, input, 1, the excepting instruction is in a delay slot.
REQ-008 SHALL have port eret, input, 1, ERET committing this cycle.
REQ-009 SHALL have port mtc0_we, input, 1, CP0 write strobe.
REQ-010 SHALL have port cp0_addr, input, 5, register number for mtc0/mfc0 (sel fixed 0).
REQ-011 SHALL have port mtc0_wdata, input, 32, write data.
REQ-012 SHALL have port mfc0_rdata, output, 32, combinational read of cp0_addr.
REQ-013 SHALL have port flush, output, 1, pipeline flush pulse.
REQ-014 SHALL have port flush_pc, output, 32, redirect target valid while flush=1.
REQ-015 SHALL have port int_req, output, 1, interrupt pending and enabled.

Function
REQ-016 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other addresses SHALL read 0 and ignore writes.
REQ-017 SHALL make Status writable only in IM[15:8], EXL[1], IE[0]; Status[22] (BEV) SHALL read 1 constantly.
REQ-018 SHALL make Cause writable only in IP[9:8]; BD[31], TI[30], IP[15:10], ExcCode[6:2] hardware-owned.
REQ-019 SHALL increment Count once every two clk cycles via an internal toggle bit, wrapping 0xFFFFFFFF->0.
REQ-020 SHALL set TI and IP[15] when Count==Compare (nonzero Compare or after any Compare write), sticky until Compare written.
REQ-021 SHALL clear TI and IP[15] on any mtc0 to Compare.
REQ-022 SHALL on exc_valid with EXL=0: EPC<=exc_bd?exc_pc-4:exc_pc, Cause.BD<=exc_bd; with EXL=1 EPC and BD SHALL be unchanged.
REQ-023 SHALL on exc_valid: EXL<=1, ExcCode<=exc_cause[6:2], and BadVAddr<=exc_badvaddr only for ExcCode 4 or 5.
REQ-024 SHALL assert flush with flush_pc=0xBFC00380 in the same cycle as exc_valid (combinational).
REQ-025 SHALL on eret: EXL<=0, flush=1, flush_pc=EPC (value before any same-cycle write).
REQ-026 SHALL give priority exc_valid > eret > mtc0_we when coincident; the losing events SHALL have no effect.
REQ-027 SHALL let an mtc0 to Count override that cycle's increment; mtc0 to Compare SHALL win over the same-cycle TI set.
REQ-028 SHALL drive int_req = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]), registered one cycle.
REQ-029 SHALL forward nothing: mfc0_rdata reflects the register value before the current cycle's write.

Reset
REQ-030 SHALL on resetn=0 clear Count, Compare, Cause, EPC, BadVAddr, count toggle, int_req; Status<=0x00400000.
REQ-031 SHALL hold flush=0 during reset; release SHALL be usable on the first rising edge after deassertion.

Structure
REQ-032 SHALL place CP0 register numbers, ExcCode values (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12) and the 0xBFC00380 vector in a shared cpu_defs package.
REQ-033 SHALL implement the Count/Compare timer as sub-module cp0_timer; all else flat.

Verification
REQ-034 SHALL cover: exc_valid, exc_cause[6:2]=12, exc_pc=0xBFC00100, bd=0 -> flush=1, flush_pc=0xBFC00380, next cycle EPC=0xBFC00100, Status.EXL=1, Cause[6:2]=12.
REQ-035 SHALL cover: ExcCode 4, bd=1, exc_pc=0x80001008, badvaddr=0x1233 -> EPC=0x80001004, Cause[31]=1, BadVAddr=0x1233.
REQ-036 SHALL cover: second exception while EXL=1 -> EPC unchanged, ExcCode updated; then eret -> flush_pc=old EPC, EXL=0 next cycle.
REQ-037 SHALL cover: mtc0 Compare=10, Count=0, Status=0x00008001 -> after 20 cycles TI=1, int_req=1 one cycle later; mtc0 Compare clears both.
REQ-038 SHALL cover: exc_valid, eret, mtc0 Status=0 in one cycle -> only exception effect; Status.IE unchanged.
REQ-039 SHALL cover: resetn pulsed low mid-count (Count=0x55) -> Count=0, Status=0x00400000 immediately, no flush.
